usb_ps2_keybuf_arb: RTL
=======================

Name: usb_ps2_keybuf_arb

Overview:
- Write-side arbiter for the key buffer. It shares the buffer's single scancode/toggle write port between two scancode producers: native PS/2 keyboard decoder (src0) and MCU-forwarded USB HID keyboard (src1).
- Each producer presents an 8-bit scancode plus a toggle strobe.
- The arbiter holds one byte per source, grants round-robin, and keeps multi-byte prefix sequences (E0/E1/F0 ...) from one source contiguous.
- It spaces writes so the downstream buffer's two-cycle write handshake is never overrun.

Parameters:
- GAP, 4: minimum clock cycles between successive toggles of kb_scancode_upd (legal 2..15).
- LOCK_TIMEOUT, 1023: cycles a prefix lock is held with no further byte from the locked source before it is released (legal 1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- src0_scancode  in  8  PS/2 source byte, valid when src0_upd changes
- src0_upd  in  1  PS/2 toggle strobe; any level change means one new byte
- src1_scancode  in  8  USB/MCU source byte, valid when src1_upd changes
- src1_upd  in  1  USB/MCU toggle strobe
- flush  in  1  synchronous clear of pending bytes, lock and overflow (driven with keybuf_reset)
- kb_scancode  out  8  byte to key buffer, registered
- kb_scancode_upd  out  1  toggle strobe to key buffer; one level change per byte
- overflow  out  1  sticky: a source byte was dropped
- busy  out  1  pend0 | pend1 | lock | (gap_cnt != 0)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - kb_scancode = 8'h00, kb_scancode_upd = 0, overflow = 0, busy = 0.
  - pend0 = pend1 = 0, lock = 0, gap_cnt = 0, timer = 0.
  - rr_last = 1, so src0 wins the first tie.
  - prev0 <= src0_upd and prev1 <= src1_upd, so a toggle level already high at reset never produces a spurious byte.
- Event detect, per source n: event_n = (srcn_upd != prevn). prevn <= srcn_upd every cycle.
- Capture, when event_n is set:
  - If pendn == 0, or source n is issued in the same cycle: holdn <= srcn_scancode, pendn <= 1.
  - Otherwise the new byte is dropped, the older held byte is kept, and overflow <= 1.
- Eligibility:
  - When lock == 1, only lock_src may be granted.
  - When lock == 0, any pending source may be granted.
- Grant and issue: when gap_cnt == 0 and an eligible source is pending, issue it.
  - Both eligible: grant the source != rr_last.
  - On issue: kb_scancode <= hold_g, kb_scancode_upd <= ~kb_scancode_upd, pend_g <= 0, rr_last <= g, gap_cnt <= GAP-1.
- Gap: gap_cnt decrements by 1 each cycle while nonzero. It saturates at 0.
- Prefix lock, evaluated on each issue:
  - Issued byte is 8'hE0, 8'hE1 or 8'hF0: lock <= 1, lock_src <= g, timer <= LOCK_TIMEOUT.
  - Any other byte from lock_src: lock <= 0.
- Lock timeout: while lock == 1 with no issue, timer decrements. Reaching 0 forces lock <= 0 the same cycle, and the other source becomes eligible at the next gap_cnt == 0.
- Latency: if srcn_upd changes before edge k with the arbiter idle (gap_cnt == 0, no lock conflict), pendn is set at edge k and kb_scancode / kb_scancode_upd change at edge k+1.
- Simultaneous events on both sources capture both bytes. Issue order follows round-robin; the second byte follows exactly GAP cycles after the first.
- flush == 1 (reset has priority if both are high):
  - Clears pend0, pend1, lock, timer, gap_cnt and overflow.
  - Source events in the same cycle are discarded, but prev registers still track their inputs.
  - kb_scancode_upd keeps its level; kb_scancode keeps its value.
  - No toggle is issued in a flush cycle.
- Reset mid-sequence (held bytes, active lock): everything returns to the reset values above. No toggle occurs during reset.
- Width rules:
  - gap_cnt is 4 bits.
  - timer is 16 bits, loaded with LOCK_TIMEOUT truncated to 16 bits.
  - No arithmetic wraps: both counters saturate at 0.

Test Plan:
- Single byte: reset, then toggle src0_upd with src0_scancode = 8'h1C -> kb_scancode = 8'h1C and kb_scancode_upd toggles exactly 2 edges after the input change; busy returns to 0 after GAP-1 further cycles.
- Tie and round-robin: toggle src0 (8'h15) and src1 (8'h04) in the same cycle -> 8'h15 is issued first, 8'h04 is issued exactly GAP (4) cycles later; a repeat tie then issues 8'h1D from src0 before 8'h05 from src1.
- Prefix lock: src0 sends E0, then 75 six cycles later; src1 sends 8'h2C right after E0 -> output order is E0, 75, 2C, and src1 is not granted while the lock is held.
- Lock timeout: LOCK_TIMEOUT = 20; src0 sends F0 only, src1 sends 8'h1A -> 8'h1A is issued 21-22 cycles after F0; overflow stays 0.
- Overflow: hold gap_cnt busy, then toggle src1 twice (8'h11, 8'h22) before it is issued -> 8'h11 is output, 8'h22 is never output, and overflow = 1 until flush.
- Flush and reset: with pending src0 byte 8'h33 and lock active, pulse flush -> no toggle ever follows and overflow/busy = 0; assert reset with src1_upd held at 1 -> no spurious byte after reset is released.

Source files
------------

// File: rtl/usb_ps2_keybuf_arb.sv
// rtl/usb_ps2_keybuf_arb.sv - round-robin write arbiter for the key buffer scancode port
module usb_ps2_keybuf_arb #(
    parameter int GAP          = 4,
    parameter int LOCK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] src0_scancode,
    input  logic       src0_upd,
    input  logic [7:0] src1_scancode,
    input  logic       src1_upd,
    input  logic       flush,
    output logic [7:0] kb_scancode,
    output logic       kb_scancode_upd,
    output logic       overflow,
    output logic       busy
);

    localparam logic [3:0]  GAP_LOAD   = 4'(GAP - 1);
    localparam logic [15:0] TIMER_LOAD = 16'(LOCK_TIMEOUT);

    logic        prev0_q, prev0_d, prev1_q, prev1_d;
    logic [7:0]  hold0_q, hold0_d, hold1_q, hold1_d;
    logic        pend0_q, pend0_d, pend1_q, pend1_d;
    logic        lock_q, lock_d, lock_src_q, lock_src_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        rr_last_q, rr_last_d;
    logic [7:0]  kb_scancode_q, kb_scancode_d;
    logic        kb_scancode_upd_q, kb_scancode_upd_d;
    logic        overflow_q, overflow_d;

    logic        event0, event1, elig0, elig1, issue0, issue1, issue;
    logic [7:0]  issue_byte;
    logic        is_prefix;

    always_comb begin
        prev0_d           = src0_upd;
        prev1_d           = src1_upd;
        hold0_d           = hold0_q;
        hold1_d           = hold1_q;
        pend0_d           = pend0_q;
        pend1_d           = pend1_q;
        lock_d            = lock_q;
        lock_src_d        = lock_src_q;
        timer_d           = timer_q;
        gap_cnt_d         = gap_cnt_q;
        rr_last_d         = rr_last_q;
        kb_scancode_d     = kb_scancode_q;
        kb_scancode_upd_d = kb_scancode_upd_q;
        overflow_d        = overflow_q;

        event0 = src0_upd ^ prev0_q;
        event1 = src1_upd ^ prev1_q;
        elig0  = pend0_q & (~lock_q | ~lock_src_q);
        elig1  = pend1_q & (~lock_q | lock_src_q);
        // On a tie the source that was not served last wins.
        issue0 = (gap_cnt_q == 4'd0) & elig0 & (~elig1 | rr_last_q);
        issue1 = (gap_cnt_q == 4'd0) & elig1 & (~elig0 | ~rr_last_q);
        issue  = issue0 | issue1;
        issue_byte = issue1 ? hold1_q : hold0_q;
        is_prefix  = (issue_byte == 8'hE0) || (issue_byte == 8'hE1) || (issue_byte == 8'hF0);

        if (flush) begin
            pend0_d    = 1'b0;
            pend1_d    = 1'b0;
            lock_d     = 1'b0;
            timer_d    = 16'd0;
            gap_cnt_d  = 4'd0;
            overflow_d = 1'b0;
        end else begin
            if (issue) begin
                kb_scancode_d     = issue_byte;
                kb_scancode_upd_d = ~kb_scancode_upd_q;
                rr_last_d         = issue1;
                gap_cnt_d         = GAP_LOAD;
                if (issue0) pend0_d = 1'b0;
                if (issue1) pend1_d = 1'b0;
                if (is_prefix) begin
                    lock_d     = 1'b1;
                    lock_src_d = issue1;
                    timer_d    = TIMER_LOAD;
                end else if (lock_q && (lock_src_q == issue1)) begin
                    lock_d = 1'b0;
                end
            end else begin
                if (gap_cnt_q != 4'd0) gap_cnt_d = gap_cnt_q - 4'd1;
                if (lock_q) begin
                    if (timer_q <= 16'd1) begin
                        timer_d = 16'd0;
                        lock_d  = 1'b0;
                    end else begin
                        timer_d = timer_q - 16'd1;
                    end
                end
            end

            // A byte issued this cycle frees its slot for a same-cycle arrival.
            if (event0) begin
                if (!pend0_q || issue0) begin
                    hold0_d = src0_scancode;
                    pend0_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            if (event1) begin
                if (!pend1_q || issue1) begin
                    hold1_d = src1_scancode;
                    pend1_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev0_q           <= src0_upd;
            prev1_q           <= src1_upd;
            hold0_q           <= 8'h00;
            hold1_q           <= 8'h00;
            pend0_q           <= 1'b0;
            pend1_q           <= 1'b0;
            lock_q            <= 1'b0;
            lock_src_q        <= 1'b0;
            timer_q           <= 16'd0;
            gap_cnt_q         <= 4'd0;
            rr_last_q         <= 1'b1;
            kb_scancode_q     <= 8'h00;
            kb_scancode_upd_q <= 1'b0;
            overflow_q        <= 1'b0;
        end else begin
            prev0_q           <= prev0_d;
            prev1_q           <= prev1_d;
            hold0_q           <= hold0_d;
            hold1_q           <= hold1_d;
            pend0_q           <= pend0_d;
            pend1_q           <= pend1_d;
            lock_q            <= lock_d;
            lock_src_q        <= lock_src_d;
            timer_q           <= timer_d;
            gap_cnt_q         <= gap_cnt_d;
            rr_last_q         <= rr_last_d;
            kb_scancode_q     <= kb_scancode_d;
            kb_scancode_upd_q <= kb_scancode_upd_d;
            overflow_q        <= overflow_d;
        end
    end

    assign kb_scancode     = kb_scancode_q;
    assign kb_scancode_upd = kb_scancode_upd_q;
    assign overflow        = overflow_q;
    assign busy            = pend0_q | pend1_q | lock_q | (gap_cnt_q != 4'd0);

endmodule
